// File: rtl/round_robin_mux4x1_if.sv
// round_robin_mux4x1_if: FIFO-side and stream-side signals of the 4:1 round-robin mux
// fifo_data_0..3 : head words of the four FWFT FIFOs
// fifo_empty     : bit i high when FIFO i is empty
// down_pause     : downstream almost-full, blocks all pops
// fifo_pop       : one-hot pop strobe back to the FIFOs
// data_out       : registered word popped the previous cycle
// valid_out      : data_out holds a popped word
// sel_out        : index of the FIFO that supplied data_out
// master = the mux, slave = the FIFOs plus downstream consumer
interface round_robin_mux4x1_if #(parameter int DATA_WIDTH = 10);
    logic [DATA_WIDTH-1:0] fifo_data_0;
    logic [DATA_WIDTH-1:0] fifo_data_1;
    logic [DATA_WIDTH-1:0] fifo_data_2;
    logic [DATA_WIDTH-1:0] fifo_data_3;
    logic [3:0]            fifo_empty;
    logic                  down_pause;
    logic [3:0]            fifo_pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [1:0]            sel_out;
    modport master (
        input  fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3, fifo_empty, down_pause,
        output fifo_pop, data_out, valid_out, sel_out
    );
    modport slave (
        output fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3, fifo_empty, down_pause,
        input  fifo_pop, data_out, valid_out, sel_out
    );
endinterface

// File: rtl/round_robin_mux4x1.sv
// round_robin_mux4x1: drains four FWFT FIFOs into one stream with rotating priority and burst grants
// clk   : rising-edge clock
// reset : synchronous, active-low
// bus   : round_robin_mux4x1_if master (FIFO heads/empties, pause in; pop strobe and registered stream out)
module round_robin_mux4x1 #(
    parameter int DATA_WIDTH = 10,
    parameter int BURST      = 4
) (
    input logic                 clk,
    input logic                 reset,
    round_robin_mux4x1_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          fsm;
    logic [1:0]      grant_idx;
    logic [3:0]      burst_cnt;
    logic [1:0]      ptr;
    logic [1:0]      cur;
    logic            cont;
    logic            found;
    logic            pop;
    logic [DATA_WIDTH-1:0] word;
    // Keep the current grant while its FIFO has data and burst allowance remains;
    // otherwise take the first non-empty FIFO starting at ptr (descending loop so the
    // nearest candidate wins).
    always_comb begin
        cont  = fsm == GRANT && !bus.fifo_empty[grant_idx] && burst_cnt < 4'(BURST);
        cur   = grant_idx;
        found = cont;
        for (int k = 3; k >= 0; k--) begin
            if (!cont && !bus.fifo_empty[ptr + 2'(k)]) begin
                cur   = ptr + 2'(k);
                found = 1'b1;
            end
        end
        pop  = reset && !bus.down_pause && found;
        word = cur == 2'd0 ? bus.fifo_data_0 :
               cur == 2'd1 ? bus.fifo_data_1 :
               cur == 2'd2 ? bus.fifo_data_2 : bus.fifo_data_3;
    end
    assign bus.fifo_pop = pop ? 4'b0001 << cur : 4'b0000;
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm           <= IDLE;
            grant_idx     <= 2'd0;
            burst_cnt     <= 4'd0;
            ptr           <= 2'd0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.sel_out   <= 2'd0;
        end else if (bus.down_pause) begin
            // Grant state frozen so the burst resumes where it left off.
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.sel_out   <= 2'd0;
        end else if (found) begin
            fsm           <= GRANT;
            grant_idx     <= cur;
            burst_cnt     <= cont ? burst_cnt + 4'd1 : 4'd1;
            ptr           <= cur + 2'd1;
            bus.data_out  <= word;
            bus.valid_out <= 1'b1;
            bus.sel_out   <= cur;
        end else begin
            fsm           <= IDLE;
            burst_cnt     <= 4'd0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.sel_out   <= 2'd0;
        end
    end
endmodule

// File: tb/tb_round_robin_mux4x1.sv
// tb_round_robin_mux4x1: table vectors on a BURST=1 mux, queue-based reference model on a BURST=4 mux
module tb_round_robin_mux4x1;
    localparam int BA = 4;
    typedef struct {
        bit         rst;
        logic [3:0] e;
        bit         p;
        logic [3:0] pop;
        bit         v;
        logic [1:0] s;
        logic [9:0] d;
    } vec_t;
    logic clk;
    logic reset;
    int checks;
    int errors;
    bit tbl;
    vec_t row;
    vec_t tv[14];
    logic [9:0] qa[4][$];
    int obs[$];
    bit mg;
    int mgi, mcnt, mptr;
    round_robin_mux4x1_if #(.DATA_WIDTH(10)) ia ();
    round_robin_mux4x1_if #(.DATA_WIDTH(10)) ib ();
    round_robin_mux4x1 #(.DATA_WIDTH(10), .BURST(BA)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    round_robin_mux4x1 #(.DATA_WIDTH(10), .BURST(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));
    assign ib.fifo_data_0 = 10'h100;
    assign ib.fifo_data_1 = 10'h101;
    assign ib.fifo_data_2 = 10'h102;
    assign ib.fifo_data_3 = 10'h103;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic step(input bit r, input bit p);
        logic [3:0] e;
        logic [3:0] ep;
        logic [9:0] ed;
        bit cont;
        int cur;
        @(negedge clk);
        reset = r;
        ia.down_pause = p;
        for (int i = 0; i < 4; i++) e[i] = qa[i].size() == 0;
        ia.fifo_empty  = e;
        ia.fifo_data_0 = e[0] ? 10'h0 : qa[0][0];
        ia.fifo_data_1 = e[1] ? 10'h0 : qa[1][0];
        ia.fifo_data_2 = e[2] ? 10'h0 : qa[2][0];
        ia.fifo_data_3 = e[3] ? 10'h0 : qa[3][0];
        if (tbl) begin
            ib.fifo_empty = row.e;
            ib.down_pause = row.p;
        end
        #1;
        cont = mg && !e[mgi] && mcnt < BA;
        cur = cont ? mgi : -1;
        for (int k = 0; k < 4; k++) if (cur < 0 && !e[(mptr + k) % 4]) cur = (mptr + k) % 4;
        ep = (r && !p && cur >= 0) ? 4'(1 << cur) : 4'b0000;
        chk("a_pop", 32'(ia.fifo_pop), 32'(ep));
        if (tbl) chk("b_pop", 32'(ib.fifo_pop), 32'(row.pop));
        @(posedge clk);
        #1;
        if (r && !p && cur >= 0) begin
            ed = qa[cur].pop_front();
            chk("a_data", 32'(ia.data_out), 32'(ed));
            chk("a_valid", 32'(ia.valid_out), 32'd1);
            chk("a_sel", 32'(ia.sel_out), 32'(cur));
            obs.push_back(cur);
            mcnt = cont ? mcnt + 1 : 1;
            mg = 1;
            mgi = cur;
            mptr = (cur + 1) % 4;
        end else begin
            chk("a_data", 32'(ia.data_out), 32'd0);
            chk("a_valid", 32'(ia.valid_out), 32'd0);
            chk("a_sel", 32'(ia.sel_out), 32'd0);
            if (!r) begin
                mg = 0; mgi = 0; mcnt = 0; mptr = 0;
            end else if (!p) begin
                mg = 0; mcnt = 0;
            end
        end
        if (tbl) begin
            chk("b_data", 32'(ib.data_out), 32'(row.d));
            chk("b_valid", 32'(ib.valid_out), 32'(row.v));
            chk("b_sel", 32'(ib.sel_out), 32'(row.s));
        end
    endtask
    task automatic fill(input int f, input int n);
        for (int i = 0; i < n; i++) qa[f].push_back(10'($urandom));
    endtask
    task automatic restart();
        step(0, 0);
        obs.delete();
    endtask
    task automatic chk_obs(input string n, input int k, input int exp);
        chk(n, (k < obs.size()) ? 32'(obs[k]) : 32'hFFFF_FFFF, 32'(exp));
    endtask
    initial begin
        int s1[8];
        checks = 0; errors = 0; tbl = 1'b1;
        mg = 0; mgi = 0; mcnt = 0; mptr = 0;
        reset = 1'b0;
        ia.down_pause = 1'b0; ia.fifo_empty = 4'hF;
        ia.fifo_data_0 = '0; ia.fifo_data_1 = '0; ia.fifo_data_2 = '0; ia.fifo_data_3 = '0;
        ib.down_pause = 1'b0; ib.fifo_empty = 4'h0;
        tv[0]  = '{0, 4'b0000, 0, 4'b0000, 0, 2'd0, 10'h000};
        tv[1]  = '{0, 4'b0000, 0, 4'b0000, 0, 2'd0, 10'h000};
        tv[2]  = '{0, 4'b0000, 0, 4'b0000, 0, 2'd0, 10'h000};
        tv[3]  = '{1, 4'b0000, 0, 4'b0001, 1, 2'd0, 10'h100};
        tv[4]  = '{1, 4'b0000, 0, 4'b0010, 1, 2'd1, 10'h101};
        tv[5]  = '{1, 4'b0000, 0, 4'b0100, 1, 2'd2, 10'h102};
        tv[6]  = '{1, 4'b0000, 0, 4'b1000, 1, 2'd3, 10'h103};
        tv[7]  = '{1, 4'b0000, 0, 4'b0001, 1, 2'd0, 10'h100};
        tv[8]  = '{1, 4'b1101, 0, 4'b0010, 1, 2'd1, 10'h101};
        tv[9]  = '{1, 4'b1101, 0, 4'b0010, 1, 2'd1, 10'h101};
        tv[10] = '{1, 4'b0000, 1, 4'b0000, 0, 2'd0, 10'h000};
        tv[11] = '{1, 4'b0000, 0, 4'b0100, 1, 2'd2, 10'h102};
        tv[12] = '{1, 4'b1111, 0, 4'b0000, 0, 2'd0, 10'h000};
        tv[13] = '{1, 4'b0000, 0, 4'b1000, 1, 2'd3, 10'h103};
        for (int i = 0; i < 14; i++) begin
            row = tv[i];
            step(row.rst, 0);
        end
        tbl = 1'b0;
        ib.fifo_empty = 4'hF;
        ib.down_pause = 1'b0;
        restart();
        fill(0, 6); fill(2, 2);
        for (int i = 0; i < 10; i++) step(1, 0);
        s1 = '{0, 0, 0, 0, 2, 2, 0, 0};
        chk("s1_len", 32'(obs.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk_obs("s1_sel", k, s1[k]);
        restart();
        fill(3, 10);
        for (int i = 0; i < 10; i++) step(1, 0);
        chk("s2_len", 32'(obs.size()), 32'd10);
        for (int i = 0; i < 2; i++) step(1, 0);
        chk("s2_len_after", 32'(obs.size()), 32'd10);
        for (int k = 0; k < 10; k++) chk_obs("s2_sel", k, 3);
        restart();
        fill(1, 8); fill(2, 3);
        step(1, 0); step(1, 0);
        for (int i = 0; i < 3; i++) step(1, 1);
        chk("s3_pause_len", 32'(obs.size()), 32'd2);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk_obs("s3_sel", 2, 1);
        chk_obs("s3_sel", 3, 1);
        chk_obs("s3_sel", 4, 2);
        restart();
        for (int i = 0; i < 4; i++) qa[i].delete();
        fill(2, 6);
        step(1, 0); step(1, 0);
        step(0, 0);
        fill(0, 2);
        obs.delete();
        step(1, 0);
        chk_obs("s4_first", 0, 0);
        restart();
        for (int i = 0; i < 4; i++) qa[i].delete();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0 && qa[i].size() < 8) fill(i, 1);
            step($urandom_range(49) != 0, $urandom_range(4) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_robin_mux4x1.md
# round_robin_mux4x1

Four-input round-robin arbiter/multiplexer: drains four first-word-fall-through virtual-channel FIFOs into one 10-bit stream, the collecting end of the 4-way split done by the routing demux. It selects among non-empty FIFOs in rotating priority, with an optional burst allowance per grant. It pops the selected FIFO and presents a registered word, valid flag and source index downstream. It honours a downstream pause (almost-full) signal.

## Interface
- DATA_WIDTH, 10, width of every data word
- BURST, 4, max consecutive pops granted to one input before priority rotates (legal 1..15)
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- fifo_data_0..fifo_data_3  in  DATA_WIDTH each  head word of FIFO i (FWFT, valid while not empty)
- fifo_empty  in  4  bit i high = FIFO i empty
- down_pause  in  1  downstream cannot accept; high blocks all pops
- fifo_pop  out  4  one-hot (or zero) pop strobe to FIFO i, combinational
- data_out  out  DATA_WIDTH  registered word popped previous cycle
- valid_out  out  1  data_out holds a popped word this cycle
- sel_out  out  2  index of FIFO that supplied data_out

## Operation
- State: fsm {IDLE, GRANT}, grant_idx[1:0], burst_cnt[3:0], ptr[1:0] (next search start).
- continue = (fsm==GRANT) && !fifo_empty[grant_idx] && burst_cnt < BURST.
- cur = grant_idx if continue; else first i with fifo_empty[i]==0 in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); none = no candidate.
- Search wraps, so the sole non-empty FIFO is re-granted after its burst expires (work-conserving, burst_cnt restarts at 1).
- fifo_pop[cur] = 1 when reset high, down_pause low and a candidate exists; otherwise fifo_pop = 0. Never more than one bit set.
- On edge with pop: data_out<=fifo_data_cur, valid_out<=1, sel_out<=cur, fsm<=GRANT, grant_idx<=cur, burst_cnt<=continue ? burst_cnt+1 : 1, ptr<=cur+1.
- On edge, no pause, no candidate: fsm<=IDLE, valid_out<=0, data_out<=0, sel_out<=0, burst_cnt<=0; ptr held.
- On edge with down_pause high: valid_out<=0, data_out<=0, sel_out<=0; fsm, grant_idx, burst_cnt, ptr held (burst resumes after pause).
- Reset (reset low at edge) overrides all: fsm=IDLE, grant_idx=0, burst_cnt=0, ptr=0, data_out=0, valid_out=0, sel_out=0; fifo_pop forced 0 combinationally while reset low.
- No arithmetic beyond mod-4 pointer increment and burst counter; burst_cnt saturates by construction (never exceeds BURST).

## Timing
- Pop to output: 1 cycle; word whose pop is high in cycle N appears on data_out with valid_out=1 in cycle N+1.
- Full throughput: one word per cycle while any FIFO non-empty and down_pause low.
- down_pause sampled same cycle as pop decision; raising it in cycle N suppresses pop in N, valid_out low in N+1.
- FIFO becoming empty mid-burst: rotation occurs the same cycle (continue false), no idle bubble if another FIFO has data.
- Reset mid-burst: pop drops immediately; all outputs zero after the edge; first grant after release searches from 0.
- Outputs held stable except on clock edges (fifo_pop excepted, combinational).

## Test plan
- Reset: hold reset low 3 cycles with all FIFOs non-empty -> fifo_pop=0000, data_out=0, valid_out=0, sel_out=0 throughout.
- BURST=1, all four FIFOs non-empty, data_i=0x100+i -> pops 0001,0010,0100,1000,0001...; data_out 0x100,0x101,0x102,0x103 with sel_out 0,1,2,3 one cycle later.
- BURST=4, FIFO0 holds 6 words, FIFO2 holds 2 -> sel_out sequence 0,0,0,0,2,2,0,0 then valid_out=0.
- Only FIFO3 non-empty, 10 words, BURST=4 -> 10 consecutive valid cycles, sel_out=3, no gap at burst boundaries.
- down_pause high for 3 cycles after 2nd word of a BURST=4 grant on FIFO1 -> fifo_pop=0000, valid_out=0 for 3 cycles, then 2 more FIFO1 words before rotation.
- reset low for 1 cycle mid-burst on FIFO2 -> all outputs 0 next cycle; after release, with FIFO0 and FIFO2 non-empty, first grant goes to FIFO0.
